// File: rtl/usc_pkg.sv
// Shared stochastic-computing constants: default frame length and decoder state encoding.
package usc_pkg;

  localparam int unsigned USC_FRAME_LOG2 = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

endpackage

// File: rtl/usc_ones_counter.sv
// Frame bit counter and ones accumulator; load restarts a frame on the current bit.
module usc_ones_counter #(
  parameter int unsigned FRAME_LOG2 = 8,
  parameter int unsigned OWIDTH     = FRAME_LOG2 + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              load,
  input  logic              stream_bit,
  output logic              frame_done,
  output logic [OWIDTH-1:0] sum
);

  logic [FRAME_LOG2-1:0] bitcnt;
  logic [OWIDTH-1:0]     acc;

  assign sum        = acc + OWIDTH'(stream_bit);
  // A load always wins: iSof on the last bit index aborts rather than completes.
  assign frame_done = en & ~load & (bitcnt == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitcnt <= '0;
      acc    <= '0;
    end else if (load) begin
      bitcnt <= FRAME_LOG2'(1);
      acc    <= OWIDTH'(stream_bit);
    end else if (en) begin
      bitcnt <= bitcnt + 1'b1;
      acc    <= (bitcnt == '1) ? '0 : sum;
    end
  end

endmodule

// File: rtl/usc_frame_decoder.sv
// Stochastic-to-binary decoder: ones count per frame with valid/ready output and overrun flag.
module usc_frame_decoder
  import usc_pkg::*;
#(
  parameter int unsigned FRAME_LOG2 = USC_FRAME_LOG2,
  parameter int unsigned OWIDTH     = FRAME_LOG2 + 1
) (
  input  logic              iClk,
  input  logic              iRstN,
  input  logic              iEn,
  input  logic              iSof,
  input  logic              iBit,
  input  logic              iReady,
  output logic              oValid,
  output logic [OWIDTH-1:0] oData,
  output logic              oOverrun
);

  state_t            state;
  logic              load;
  logic              cnt_en;
  logic              frame_done;
  logic [OWIDTH-1:0] sum;

  assign load   = iEn & iSof;
  assign cnt_en = iEn & (state == COUNT);

  usc_ones_counter #(
    .FRAME_LOG2 (FRAME_LOG2),
    .OWIDTH     (OWIDTH)
  ) u_counter (
    .clk        (iClk),
    .rst_n      (iRstN),
    .en         (cnt_en),
    .load       (load),
    .stream_bit (iBit),
    .frame_done (frame_done),
    .sum        (sum)
  );

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state    <= IDLE;
      oValid   <= 1'b0;
      oData    <= '0;
      oOverrun <= 1'b0;
    end else begin
      oOverrun <= 1'b0;
      if (load) state <= COUNT;
      if (frame_done) begin
        oData    <= sum;
        oValid   <= 1'b1;
        oOverrun <= oValid & ~iReady;
      end else if (oValid & iReady) begin
        oValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_usc_frame_decoder.sv
// Directed bench for usc_frame_decoder with a frame-level reference model compared every cycle.
module tb_usc_frame_decoder;

  localparam int unsigned FRAME = 256;

  logic       iClk = 1'b0;
  logic       iRstN = 1'b0;
  logic       iEn = 1'b0;
  logic       iSof = 1'b0;
  logic       iBit = 1'b0;
  logic       iReady = 1'b0;
  logic       oValid;
  logic [8:0] oData;
  logic       oOverrun;

  int checks = 0;
  int errors = 0;

  usc_frame_decoder #(.FRAME_LOG2(8), .OWIDTH(9)) dut (
    .iClk     (iClk),
    .iRstN    (iRstN),
    .iEn      (iEn),
    .iSof     (iSof),
    .iBit     (iBit),
    .iReady   (iReady),
    .oValid   (oValid),
    .oData    (oData),
    .oOverrun (oOverrun)
  );

  always #5 iClk = ~iClk;

  // Reference model: collect accepted bits since the last start and count them per full frame.
  bit q[$];
  bit m_active = 0;
  int m_valid = 0;
  int m_data = 0;
  int m_overrun = 0;

  always @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      q.delete();
      m_active  = 0;
      m_valid   = 0;
      m_data    = 0;
      m_overrun = 0;
    end else begin
      bit done;
      int result;
      done = 0;
      result = 0;
      if (iEn) begin
        if (iSof) begin
          q.delete();
          m_active = 1;
        end
        if (m_active) begin
          q.push_back(iBit);
          if (q.size() == FRAME) begin
            foreach (q[i]) result += int'(q[i]);
            q.delete();
            done = 1;
          end
        end
      end
      if (done) begin
        m_overrun = (m_valid != 0 && !iReady) ? 1 : 0;
        m_valid   = 1;
        m_data    = result;
      end else begin
        m_overrun = 0;
        if (m_valid != 0 && iReady) m_valid = 0;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge iClk);
      #1;
      if (iRstN) begin
        check("cyc_valid", int'(oValid), m_valid);
        if (m_valid != 0) check("cyc_data", int'(oData), m_data);
        check("cyc_overrun", int'(oOverrun), m_overrun);
      end
    end
  end

  task automatic step(input logic en, input logic sof, input logic b, input logic rdy);
    @(negedge iClk);
    iEn = en;
    iSof = sof;
    iBit = b;
    iReady = rdy;
  endtask

  task automatic settle;
    @(posedge iClk);
    #2;
  endtask

  task automatic do_reset;
    @(negedge iClk);
    iRstN = 1'b0;
    #1;
    check("rst_valid", int'(oValid), 0);
    check("rst_data", int'(oData), 0);
    check("rst_overrun", int'(oOverrun), 0);
    @(negedge iClk);
    iRstN = 1'b1;
  endtask

  initial begin
    #100_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int c;

    // 1: full frame of ones
    do_reset();
    step(0, 0, 0, 1);
    for (int i = 0; i < 256; i++) step(1, i == 0, 1, 1);
    settle();
    check("t1_valid", int'(oValid), 1);
    check("t1_data", int'(oData), 256);
    step(0, 0, 0, 1);
    settle();
    check("t1_drop", int'(oValid), 0);

    // 2: alternating bits, then with gaps in iEn
    for (int i = 0; i < 256; i++) step(1, i == 0, (i % 2) == 0, 1);
    settle();
    check("t2_data", int'(oData), 128);
    n = 0;
    c = 0;
    while (n < 256) begin
      if (c % 3 == 2) step(0, 0, 1, 1);
      else begin
        step(1, n == 0, (n % 2) == 0, 1);
        n++;
      end
      c++;
    end
    settle();
    check("t2_gap_valid", int'(oValid), 1);
    check("t2_gap_data", int'(oData), 128);

    // 3: bits before iSof ignored
    do_reset();
    for (int i = 0; i < 40; i++) step(1, 0, 1, 1);
    for (int i = 0; i < 256; i++) step(1, i == 0, i < 64, 1);
    settle();
    check("t3_data", int'(oData), 64);

    // 4: restart mid-frame discards the partial frame
    step(0, 0, 0, 1);
    for (int i = 0; i < 100; i++) step(1, i == 0, 1, 1);
    for (int i = 0; i < 256; i++) begin
      step(1, i == 0, i < 10, 1);
      if (i == 200) begin
        settle();
        check("t4_no_out", int'(oValid), 0);
      end
    end
    settle();
    check("t4_data", int'(oData), 10);

    // 5: overrun with iReady low
    step(0, 0, 0, 0);
    for (int i = 0; i < 256; i++) step(1, i == 0, 0, 0);
    settle();
    check("t5_zero_valid", int'(oValid), 1);
    check("t5_zero_data", int'(oData), 0);
    for (int i = 0; i < 256; i++) begin
      step(1, 0, 1, 0);
      if (i == 50) begin
        settle();
        check("t5_hold", int'(oData), 0);
      end
    end
    settle();
    check("t5_ovr_data", int'(oData), 256);
    check("t5_ovr_pulse", int'(oOverrun), 1);
    step(0, 0, 0, 0);
    settle();
    check("t5_ovr_end", int'(oOverrun), 0);
    check("t5_still_valid", int'(oValid), 1);
    step(0, 0, 0, 1);
    settle();
    check("t5_xfer", int'(oValid), 0);

    // 6: reset mid-frame, then bits without iSof ignored
    for (int i = 0; i < 256; i++) step(1, i == 0, 1, 0);
    for (int i = 0; i < 130; i++) step(1, 0, 1, 0);
    settle();
    check("t6_pending", int'(oValid), 1);
    do_reset();
    for (int i = 0; i < 300; i++) step(1, 0, 1, 1);
    settle();
    check("t6_ignored", int'(oValid), 0);
    for (int i = 0; i < 256; i++) step(1, i == 0, i != 0, 1);
    settle();
    check("t6_data", int'(oData), 255);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    settle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
